// File: rtl/uart_rx_fifo_if.sv
// Receive-side word handshake: the receiver presents P_data/data_valid and the
// consumer answers with data_ready.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_data;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output P_data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  P_data,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity and
// second stop bit, registered error pulses and a small output FIFO.
module uart_rx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        RX_IN,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic                        PAR_EN,
    input  logic                        PAR_TYP,
    input  logic                        STP2,
    uart_rx_fifo_if.master              out_if,
    output logic                        par_err,
    output logic                        stp_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                      rx_p0;
    logic                      rx_s;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic                      par_bad_q, par_bad_d;

    logic [PRESCALE_WIDTH-1:0] p_lat;
    logic                      par_en_lat;
    logic                      par_typ_lat;
    logic                      stp2_lat;
    logic [2:0]                smp;
    logic [DATA_WIDTH-1:0]     shreg;

    logic                      latch_cfg;
    logic                      shift_en;
    logic                      push_req;
    logic                      stp_err_d;
    logic                      par_err_d;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_s0, at_s1, at_s2, at_vote, at_end;
    logic                      maj;

    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      valid;
    logic                      full;
    logic                      pop;
    logic                      wr_en;
    logic                      ovr_d;

    // Stage p0/s: two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= RX_IN;
            rx_s  <= rx_p0;
        end
    end

    assign half    = p_lat >> 1;
    assign at_s0   = (edge_q == half - PRESCALE_WIDTH'(1));
    assign at_s1   = (edge_q == half);
    assign at_s2   = (edge_q == half + PRESCALE_WIDTH'(1));
    assign at_vote = (edge_q == half + PRESCALE_WIDTH'(2));
    assign at_end  = (edge_q == p_lat - PRESCALE_WIDTH'(1));
    assign maj     = majority3(smp);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = at_end ? '0 : edge_q + PRESCALE_WIDTH'(1);
        bit_d     = bit_q;
        par_bad_d = par_bad_q;
        latch_cfg = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        stp_err_d = 1'b0;
        par_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The detection cycle itself is edge 0 of the start bit.
                edge_d    = PRESCALE_WIDTH'(1);
                bit_d     = '0;
                par_bad_d = 1'b0;
                if (!rx_s) begin
                    state_d   = S_START;
                    latch_cfg = 1'b1;
                end
            end
            S_START: begin
                if (at_vote && maj) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = at_vote;
                if (at_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_lat ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_vote) begin
                    par_bad_d = (parity_bit(shreg, par_typ_lat) != maj);
                end
                if (at_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                // Leave at the vote point so a back-to-back start edge is seen.
                if (at_vote) begin
                    if (!maj) begin
                        stp_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (!stp2_lat) begin
                        state_d   = S_IDLE;
                        par_err_d = par_bad_q;
                        push_req  = !par_bad_q;
                    end
                end else if (at_end) begin
                    state_d = S_STOP2;
                end
            end
            S_STOP2: begin
                if (at_vote) begin
                    state_d = S_IDLE;
                    if (!maj) begin
                        stp_err_d = 1'b1;
                    end else begin
                        par_err_d = par_bad_q;
                        push_req  = !par_bad_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (latch_cfg) begin
            p_lat       <= prescale;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
            stp2_lat    <= STP2;
        end
        if (at_s0) smp[0] <= rx_s;
        if (at_s1) smp[1] <= rx_s;
        if (at_s2) smp[2] <= rx_s;
        if (shift_en) begin
            shreg <= {maj, shreg[DATA_WIDTH-1:1]};
        end
    end

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid && out_if.data_ready;
    assign wr_en = push_req && (!full || pop);
    assign ovr_d = push_req && full && !pop;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // Stage p1: registered single-cycle event pulses
    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            par_err <= par_err_d;
            stp_err <= stp_err_d;
            overrun <= ovr_d;
        end
    end

    assign out_if.data_valid = valid;
    assign out_if.P_data     = valid ? mem[rd_ptr] : '0;
    assign fifo_count        = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and randomised serial frames checked against
// a frame-level reference model (expected words, error and overrun counts).
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b0;
    logic          RX_IN   = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          PAR_EN  = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STP2    = 1'b0;
    logic          par_err;
    logic          stp_err;
    logic          overrun;
    logic [CW-1:0] fifo_count;

    uart_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_fifo #(
        .DATA_WIDTH(DW),
        .PRESCALE_WIDTH(PW),
        .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .prescale(prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .STP2(STP2),
        .out_if(bus),
        .par_err(par_err),
        .stp_err(stp_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Output monitor: every accepted word and every high cycle of each pulse.
    logic [DW-1:0] got_q[$];
    int n_par = 0;
    int n_stp = 0;
    int n_ovr = 0;
    int n_valid = 0;

    always @(negedge CLK) begin
        if (RST) begin
            if (bus.data_valid && bus.data_ready) got_q.push_back(bus.P_data);
            if (bus.data_valid) n_valid++;
            if (par_err) n_par++;
            if (stp_err) n_stp++;
            if (overrun) n_ovr++;
        end
    end

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int exp_par = 0;
    int exp_stp = 0;
    int exp_ovr = 0;
    int occ     = 0;
    int seen    = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = good frame, 1 = stop error, 2 = parity error
    function automatic int outcome(input logic [DW-1:0] d, input logic pe, input logic pt,
                                   input logic s2, input logic pb, input logic st1,
                                   input logic st2);
        logic want;
        want = (($countones(d) % 2) != 0) ^ pt;
        if (!st1 || (s2 && !st2)) return 1;
        if (pe && (pb != want)) return 2;
        return 0;
    endfunction

    task automatic model_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input logic s2, input logic pb, input logic st1, input logic st2);
        int r;
        r = outcome(d, pe, pt, s2, pb, st1, st2);
        if (r == 1) exp_stp++;
        else if (r == 2) exp_par++;
        else if (!bus.data_ready && occ == FD) exp_ovr++;
        else begin
            exp_q.push_back(d);
            if (!bus.data_ready) occ++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic v, input int p, input int flip_at);
        for (int c = 0; c < p; c++) begin
            RX_IN = (c == flip_at) ? ~v : v;
            tick();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pe,
                              input logic pt, input logic s2, input logic pb,
                              input logic st1, input logic st2, input int glitch_bit);
        model_frame(d, pe, pt, s2, pb, st1, st2);
        prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STP2     = s2;
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p, (i == glitch_bit) ? p / 2 : -1);
        if (pe) drive_bit(pb, p, -1);
        drive_bit(st1, p, -1);
        if (s2) drive_bit(st2, p, -1);
        RX_IN = 1'b1;
    endtask

    task automatic check_events(input string tag);
        check({tag, "/par_err"}, n_par, exp_par);
        check({tag, "/stp_err"}, n_stp, exp_stp);
        check({tag, "/overrun"}, n_ovr, exp_ovr);
    endtask

    task automatic check_words(input string tag);
        check({tag, "/nwords"}, got_q.size(), exp_q.size());
        for (int i = seen; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "/word"}, got_q[i], exp_q[i]);
        seen = got_q.size();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/valid"}, bus.data_valid, 0);
        check({tag, "/P_data"}, bus.P_data, 0);
        check({tag, "/count"}, fifo_count, 0);
        check({tag, "/par_err"}, par_err, 0);
        check({tag, "/stp_err"}, stp_err, 0);
        check({tag, "/overrun"}, overrun, 0);
    endtask

    initial begin
        int            base;
        logic [DW-1:0] pd;
        logic [DW-1:0] rd;
        int            rp;
        logic          rpe, rpt, rs2, rpb, rst1, good;

        bus.data_ready = 1'b1;
        RST = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        RST = 1'b1;
        idle(4);

        base = n_valid;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(24);
        check("a5/valid_cycles", n_valid - base, 1);
        check_events("a5");
        check_words("a5");

        send_frame(8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(48);
        check_events("par");
        check_words("par");
        check("par/valid", bus.data_valid, 0);
        check("par/count", fifo_count, 0);

        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle(24);
        check_events("stp2_bad");
        check_words("stp2_bad");
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(24);
        check_events("stp2_good");
        check_words("stp2_good");

        RX_IN = 1'b0;
        tick();
        idle(24);
        check_events("glitch");
        check_words("glitch");
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        idle(24);
        check_events("vote");
        check_words("vote");

        bus.data_ready = 1'b0;
        occ = 0;
        for (int i = 1; i <= 5; i++)
            send_frame(DW'(i), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(24);
        check("ovr/count", fifo_count, FD);
        check("ovr/valid", bus.data_valid, 1);
        check("ovr/head", bus.P_data, 8'h01);
        check_events("ovr");
        bus.data_ready = 1'b1;
        occ = 0;
        idle(10);
        check_words("drain");
        check("drain/count", fifo_count, 0);

        bus.data_ready = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(24);
        check("prerst/count", fifo_count, 1);
        pd = 8'hC3;
        drive_bit(1'b0, 8, -1);
        for (int i = 0; i < 4; i++) drive_bit(pd[i], 8, -1);
        RX_IN = pd[4];
        repeat (4) tick();
        RST = 1'b0;
        repeat (2) tick();
        check_quiet("midrst");
        RX_IN = 1'b1;
        tick();
        RST = 1'b1;
        void'(exp_q.pop_back());
        occ = 0;
        bus.data_ready = 1'b1;
        idle(24);
        send_frame(8'h9E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(24);
        check_events("after_rst");
        check_words("after_rst");

        for (int k = 0; k < 10; k++) begin
            rd   = DW'($urandom);
            rp   = 2 * $urandom_range(4, 15);
            rpe  = 1'($urandom_range(0, 1));
            rpt  = 1'($urandom_range(0, 1));
            rs2  = 1'($urandom_range(0, 1));
            good = (($countones(rd) % 2) != 0) ^ rpt;
            rpb  = ($urandom_range(0, 3) == 0) ? ~good : good;
            rst1 = rs2 ? 1'b1 : ($urandom_range(0, 4) != 0);
            send_frame(rd, rp, rpe, rpt, rs2, rpb, rst1, 1'b1, -1);
            idle(3 * rp);
            check_events("rand");
            check_words("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver. It adds the following:
- configurable data width;
- optional second stop bit;
- 3-sample majority voting;
- registered error flags;
- an output FIFO with valid/ready handshake.

It sits between the asynchronous serial pin and the system-side consumer (register file / command decoder) in the same clock domain as the UART TX.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9)
PRESCALE_WIDTH, 6, width of prescale input
FIFO_DEPTH, 4, received-word buffer depth (power of 2, >=2)

Ports:
CLK  input  1  receiver clock (oversampling clock)
RST  input  1  synchronous active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to CLK
prescale  input  PRESCALE_WIDTH  oversampling ratio P; legal = even, 8..2^PRESCALE_WIDTH-2
PAR_EN  input  1  1 = parity bit present after data
PAR_TYP  input  1  0 = even, 1 = odd parity
STP2  input  1  1 = two stop bits expected
P_data  output  DATA_WIDTH  FIFO head word
data_valid  output  1  FIFO non-empty; P_data valid
data_ready  input  1  consumer accepts head word when data_valid=1
par_err  output  1  one-cycle pulse: parity mismatch, frame discarded
stp_err  output  1  one-cycle pulse: stop bit sampled 0, frame discarded
overrun  output  1  one-cycle pulse: good frame dropped, FIFO full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (RST=0 at posedge CLK): FSM=IDLE, counters=0, FIFO empty, P_data=0, data_valid=0, par_err=stp_err=overrun=0, fifo_count=0. Reset mid-frame aborts the frame; nothing is pushed.
- RX_IN passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised rx_s. This adds 2 cycles of input latency.
- Edge counter runs 0..P-1 per bit. Bit counter indexes bits within the frame.
- Sampling: rx_s is captured at edge counts P/2-1, P/2 and P/2+1. Bit value = majority of the 3 samples, valid at edge count P/2+2.
- PAR_EN, PAR_TYP, STP2 and prescale are latched on start-edge detect. Changes mid-frame have no effect.
- FSM states:
  - IDLE -> START on rx_s=0.
  - START: majority=1 -> IDLE (glitch, no flag); else at edge P-1 -> DATA.
  - DATA: DATA_WIDTH bits, LSB first, shifted into a holding register. After the last bit -> PARITY if PAR_EN, else STOP1.
  - PARITY: compute expected = ^data XOR PAR_TYP; record mismatch. At edge P-1 -> STOP1.
  - STOP1: at majority-valid point: sample=0 -> stp_err; else if STP2 -> STOP2 at edge P-1; else frame done.
  - STOP2: same check as STOP1; then frame done.
  - Frame done / error: return to IDLE at the stop-bit majority-valid point, not the bit end, so back-to-back frames with a single stop bit are not missed.
- Error priority: stp_err takes precedence; par_err pulses only if the stop bit(s) were good. Errored frames are never pushed.
- Push: a good frame is written to the FIFO on the cycle FSM leaves the final stop bit.
  - data_valid rises the following cycle when the FIFO was empty (push-to-valid latency = 1 cycle).
- Pop: occurs on any cycle with data_valid=1 and data_ready=1. P_data shows the next word the following cycle. data_ready while data_valid=0 is ignored.
- Full FIFO:
  - Push without a same-cycle pop -> word dropped, overrun pulses 1 cycle, contents unchanged.
  - Push with a same-cycle pop -> both occur; count unchanged; no overrun.
- Empty FIFO with simultaneous push and pop: no pop occurs (data_valid=0); the push is accepted.
- Pointers wrap modulo FIFO_DEPTH. fifo_count tracks 0..FIFO_DEPTH exactly.
- Error pulses are registered, exactly 1 cycle wide. Each is asserted at most once per frame.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5, data_ready=1 -> one data_valid pulse with P_data=0xA5; no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, byte 0x07 with parity bit 0 (wrong) -> par_err 1-cycle pulse; data_valid stays 0; fifo_count=0.
- STP2=1, byte 0x3C, second stop bit driven 0 -> stp_err pulse, no push. Repeat with both stops=1 -> 0x3C received.
- 1-cycle low glitch on idle RX_IN; then a mid-bit 1-cycle inversion inside data bit 3 of 0x55 -> no start detected for the glitch; 0x55 received intact (majority vote).
- data_ready=0, send 5 back-to-back frames 0x01..0x05 with FIFO_DEPTH=4:
  - fifo_count reaches 4; overrun pulses on frame 5;
  - then data_ready=1 pops 0x01,0x02,0x03,0x04 in order.
- Assert RST=0 during data bit 4 of a frame, release, then send 0x9E -> no output from the aborted frame; 0x9E received; all outputs 0 during reset.
